// File: rtl/quad_seq_pkg.sv
// rtl/quad_seq_pkg.sv - shared state enum and {b,a} phase encodings for the quadrature sequence encoder
package quad_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_PH2  = 3'd2,
        S_PH3  = 3'd3,
        S_GAP  = 3'd4
    } qs_state_e;

    localparam logic [1:0] BA_IDLE = 2'b00;

    localparam logic [1:0] INC_PH1 = 2'b01;
    localparam logic [1:0] INC_PH2 = 2'b11;
    localparam logic [1:0] INC_PH3 = 2'b10;
    localparam logic [1:0] INC_GAP = 2'b00;

    localparam logic [1:0] DEC_PH1 = 2'b10;
    localparam logic [1:0] DEC_PH2 = 2'b11;
    localparam logic [1:0] DEC_PH3 = 2'b01;
    localparam logic [1:0] DEC_GAP = 2'b00;

    // {b,a} to drive while in state st; dir 0 = increment, 1 = decrement
    function automatic logic [1:0] phase_code(input logic dir, input qs_state_e st);
        logic [1:0] code;
        code = BA_IDLE;
        case (st)
            S_PH1:   code = dir ? DEC_PH1 : INC_PH1;
            S_PH2:   code = dir ? DEC_PH2 : INC_PH2;
            S_PH3:   code = dir ? DEC_PH3 : INC_PH3;
            S_GAP:   code = dir ? DEC_GAP : INC_GAP;
            default: code = BA_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-phase hold counter; expire pulses HOLD_CYCLES cycles after start
module phase_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic expire
);

    logic [7:0] cnt_q;
    logic       active_q;

    assign expire = active_q && (cnt_q == 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
        end else if (start) begin
            cnt_q    <= 8'(HOLD_CYCLES - 1);
            active_q <= 1'b1;
        end else if (expire) begin
            active_q <= 1'b0;
        end else if (active_q) begin
            cnt_q    <= cnt_q - 8'd1;
        end
    end

endmodule

// File: rtl/quad_seq_encoder.sv
// rtl/quad_seq_encoder.sv - emits one four-phase quadrature sensor sequence per accepted request
module quad_seq_encoder
    import quad_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int COUNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_dir,
    output logic               req_ready,
    output logic               a,
    output logic               b,
    output logic               inc_done,
    output logic               dec_done,
    output logic [COUNT_W-1:0] net_count
);

    qs_state_e          state_q;
    logic               dir_q;
    logic [1:0]         ba_q;
    logic               inc_done_q;
    logic               dec_done_q;
    logic [COUNT_W-1:0] count_q;
    logic               timer_start;
    logic               timer_expire;

    // Restart the timer on acceptance and on every phase advance except leaving GAP
    assign timer_start = ((state_q == S_IDLE) && req_valid) ||
                         (timer_expire && (state_q != S_GAP) && (state_q != S_IDLE));

    phase_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (timer_start),
        .expire(timer_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            dir_q      <= 1'b0;
            ba_q       <= BA_IDLE;
            inc_done_q <= 1'b0;
            dec_done_q <= 1'b0;
            count_q    <= '0;
        end else begin
            inc_done_q <= 1'b0;
            dec_done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (req_valid) begin
                    state_q <= S_PH1;
                    dir_q   <= req_dir;
                    ba_q    <= phase_code(req_dir, S_PH1);
                end
                S_PH1: if (timer_expire) begin
                    state_q <= S_PH2;
                    ba_q    <= phase_code(dir_q, S_PH2);
                end
                S_PH2: if (timer_expire) begin
                    state_q <= S_PH3;
                    ba_q    <= phase_code(dir_q, S_PH3);
                end
                S_PH3: if (timer_expire) begin
                    state_q <= S_GAP;
                    ba_q    <= phase_code(dir_q, S_GAP);
                end
                S_GAP: if (timer_expire) begin
                    state_q    <= S_IDLE;
                    ba_q       <= BA_IDLE;
                    inc_done_q <= !dir_q;
                    dec_done_q <= dir_q;
                    count_q    <= dir_q ? count_q - COUNT_W'(1) : count_q + COUNT_W'(1);
                end
                default: begin
                    state_q <= S_IDLE;
                    ba_q    <= BA_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign a         = ba_q[0];
    assign b         = ba_q[1];
    assign inc_done  = inc_done_q;
    assign dec_done  = dec_done_q;
    assign net_count = count_q;

endmodule
